sequence_bit_serializer: RTL and testbench
==========================================

SEQUENCE_BIT_SERIALIZER -- requirements
Module: sequence_bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (legal 2..16).
REQ-002 Parameter LSB_FIRST, default 0; 0 = MSB shifted first, 1 = LSB shifted first.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  word-offer strobe; qualified by ready.
REQ-006 data_in  input  WIDTH  parallel word, sampled when load && ready.
REQ-007 enable  input  1  bit-step permission; 0 stalls shifting.
REQ-008 ready  output  1  high when a word can be accepted this cycle.
REQ-009 x  output  1  current serial bit, driving the downstream recognizer x input.
REQ-010 x_valid  output  1  high when x is a real bit consumed this cycle.
REQ-011 busy  output  1  high while in SHIFT.
REQ-012 words_sent  output  8  count of completed words, wraps 255->0.

Function
REQ-013 Storage SHALL be a WIDTH-bit shift register, a log2-sized bit counter, and a one-word holding register with a full flag.
REQ-014 FSM SHALL have two states: IDLE (shift register empty) and SHIFT.
REQ-015 ready SHALL equal !hold_full, combinationally; a load with ready=0 SHALL be ignored, with no state change.
REQ-016 In IDLE, load && ready SHALL place data_in directly into the shift register, clear the bit counter, and move to SHIFT on the next edge.
REQ-017 In SHIFT, load && ready SHALL place data_in into the holding register and set hold_full.
REQ-018 In SHIFT, x SHALL be the head bit: bit WIDTH-1 when LSB_FIRST=0, bit 0 when LSB_FIRST=1.
REQ-019 x_valid SHALL equal busy && enable.
REQ-020 On each edge with x_valid=1, the register SHALL shift by one toward the head and the bit counter SHALL increment.
REQ-021 With enable=0, shift register, counter, and x SHALL hold.
REQ-022 Last bit (counter==WIDTH-1 && x_valid) with hold_full=1: the holding word SHALL move into the shift register, hold_full SHALL clear, and the counter SHALL reset, staying in SHIFT with no idle gap.
REQ-023 Last bit with hold_full=0 and load=1 on the same cycle: data_in SHALL go straight into the shift register, staying in SHIFT with no gap.
REQ-024 Last bit with hold_full=0 and load=0: the FSM SHALL return to IDLE.
REQ-025 When hold_full=1, REQ-022 applies and ready=0 that cycle, so a simultaneous load is impossible.
REQ-026 words_sent SHALL increment by 1 on every last-bit edge, modulo 256.
REQ-027 In IDLE, x SHALL be 0 and x_valid 0, so the downstream Mealy output cannot assert spuriously.
REQ-028 busy SHALL be 1 exactly while in SHIFT.
REQ-029 Latency: the first bit of a word loaded in IDLE SHALL appear on x one cycle after the load edge.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, clear the shift register, counter, holding register, hold_full and words_sent, and drive x=0, x_valid=0, busy=0, ready=1.
REQ-031 Reset asserted mid-word SHALL discard the partial word and any held word, with no further x_valid pulses.
REQ-032 Outputs SHALL be stable from the first clock edge after reset release.

Verification
REQ-033 WIDTH=8, LSB_FIRST=0, enable=1; load 8'hB4 in IDLE -> x = 1,0,1,1,0,1,0,0 over 8 consecutive x_valid cycles, then IDLE, words_sent 0->1.
REQ-034 Load 8'hF0, then load 8'h0F two cycles later -> ready drops to 0 after the second load, 16 contiguous valid bits 11110000 00001111 with no gap, ready back to 1 at the hand-over edge, words_sent=2.
REQ-035 Load 8'hAA with enable toggling 1,0,0,1,... -> x holds across stalls, exactly 8 x_valid pulses carrying 10101010.
REQ-036 Assert reset after the 3rd bit of 8'hFF with a word held -> busy=0, ready=1, words_sent=0 immediately, and no x_valid afterwards until a new load.
REQ-037 Stream 257 words back-to-back -> words_sent reads 1, with no idle cycle between any words.
REQ-038 LSB_FIRST=1; load 8'h01 -> x = 1,0,0,0,0,0,0,0; load while ready=0 -> word dropped, output stream unchanged.

Source files
------------

// File: rtl/sequence_bit_serializer.sv
// Parallel-to-serial word shifter with one-word holding register, feeding a
// downstream bit-serial recognizer back-to-back words with no idle gap.
module sequence_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [7:0]       words_sent
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       words_q, words_d;

    logic             busy_s;
    logic             head_s;
    logic             valid_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] shifted_s;

    assign busy_s    = (state_q == ST_SHIFT);
    assign head_s    = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign shifted_s = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
    assign valid_s   = busy_s & enable;
    assign accept_s  = load & ~hold_full_q;
    assign last_s    = valid_s & (cnt_q == LAST_CNT);

    // x is gated to 0 outside SHIFT so the downstream recognizer never sees a stale bit
    assign ready      = ~hold_full_q;
    assign busy       = busy_s;
    assign x_valid    = valid_s;
    assign x          = busy_s & head_s;
    assign words_sent = words_q;

    // Next-state logic: load routing, shifting, and word hand-over
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        words_d     = words_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shreg_d = data_in;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    words_d = words_q + 8'd1;
                    cnt_d   = {CW{1'b0}};
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (load) begin
                        shreg_d = data_in;
                    end else begin
                        shreg_d = {WIDTH{1'b0}};
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (valid_s) begin
                        shreg_d = shifted_s;
                        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        shreg_d = shreg_q;
                    end
                    if (accept_s) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end else begin
                        hold_full_d = hold_full_q;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                shreg_d     = {WIDTH{1'b0}};
                cnt_d       = {CW{1'b0}};
                hold_full_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            words_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            words_q     <= words_d;
        end
    end

endmodule

// File: tb/tb_sequence_bit_serializer.sv
// Scoreboard bench: stimulus pushes expected serial bits, per-DUT monitors pop
// and compare on every x_valid cycle. dut0 is MSB-first, dut1 is LSB-first.
module tb_sequence_bit_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic       load0, en0, ready0, x0, xv0, busy0;
    logic [7:0] data0, ws0;
    logic       load1, en1, ready1, x1, xv1, busy1;
    logic [7:0] data1, ws1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic q0[$];
    logic q1[$];

    always #5 clock = ~clock;

    sequence_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
        .clock(clock), .reset(reset), .load(load0), .data_in(data0), .enable(en0),
        .ready(ready0), .x(x0), .x_valid(xv0), .busy(busy0), .words_sent(ws0)
    );

    sequence_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
        .clock(clock), .reset(reset), .load(load1), .data_in(data1), .enable(en1),
        .ready(ready1), .x(x1), .x_valid(xv1), .busy(busy1), .words_sent(ws1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push0(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q0.push_back(w[i]);
    endtask

    task automatic push1(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q1.push_back(w[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load0 = 1'b0; load1 = 1'b0;
        en0   = 1'b1; en1   = 1'b1;
        tick();
        tick();
        q0.delete();
        q1.delete();
        reset = 1'b1;
        tick();
    endtask

    // Monitor for dut0: pop expected bit on every valid cycle
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("x0_valid_eq", xv0, busy0 & en0);
            if (xv0) begin
                if (q0.size() == 0) check("x0_unexpected_valid", 1, 0);
                else                check("x0_bit", x0, q0.pop_front());
            end else if (busy0 && q0.size() > 0) begin
                check("x0_stall_hold", x0, q0[0]);
            end else if (!busy0) begin
                check("x0_idle_zero", x0, 0);
            end
        end
    end

    // Monitor for dut1
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (xv1) begin
                if (q1.size() == 0) check("x1_unexpected_valid", 1, 0);
                else                check("x1_bit", x1, q1.pop_front());
            end else if (!busy1) begin
                check("x1_idle_zero", x1, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int n, k;
        reset = 1'b0;
        load0 = 1'b0; data0 = 8'h00; en0 = 1'b1;
        load1 = 1'b0; data1 = 8'h00; en1 = 1'b1;
        tick();
        tick();
        check("rst_ready",  ready0, 1);
        check("rst_busy",   busy0,  0);
        check("rst_x",      x0,     0);
        check("rst_xvalid", xv0,    0);
        check("rst_words",  ws0,    0);
        check("rst_ready1", ready1, 1);
        reset = 1'b1;
        tick();

        // single word B4, MSB first
        data0 = 8'hB4; load0 = 1'b1; push0(8'hB4);
        tick();
        load0 = 1'b0;
        check("t1_busy", busy0, 1);
        repeat (8) tick();
        check("t1_idle",  busy0, 0);
        check("t1_words", ws0, 1);
        check("t1_drain", q0.size(), 0);
        do_reset();

        // F0 then 0F two cycles later: hold register hand-over
        data0 = 8'hF0; load0 = 1'b1; push0(8'hF0);
        tick();
        load0 = 1'b0;
        tick();
        data0 = 8'h0F; load0 = 1'b1;
        check("t2_ready_before", ready0, 1);
        push0(8'h0F);
        tick();
        load0 = 1'b0;
        check("t2_ready_drop", ready0, 0);
        repeat (5) tick();
        check("t2_ready_still0", ready0, 0);
        tick();
        check("t2_ready_handover", ready0, 1);
        check("t2_busy_handover",  busy0, 1);
        repeat (8) tick();
        check("t2_idle",  busy0, 0);
        check("t2_words", ws0, 2);
        check("t2_drain", q0.size(), 0);
        do_reset();

        // AA with enable 1,0,0,1 stalls
        data0 = 8'hAA; load0 = 1'b1; push0(8'hAA);
        tick();
        load0 = 1'b0;
        pat = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            en0 = pat[i % 4];
            tick();
        end
        en0 = 1'b1;
        check("t3_idle",  busy0, 0);
        check("t3_words", ws0, 1);
        check("t3_drain", q0.size(), 0);
        do_reset();

        // reset mid-word with a held word
        data0 = 8'hFF; load0 = 1'b1; push0(8'hFF);
        tick();
        data0 = 8'h3C;
        tick();
        load0 = 1'b0;
        check("t4_held", ready0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t4_busy",   busy0, 0);
        check("t4_ready",  ready0, 1);
        check("t4_words",  ws0, 0);
        check("t4_xvalid", xv0, 0);
        q0.delete();
        tick();
        reset = 1'b1;
        repeat (20) tick();
        check("t4_still_idle", busy0, 0);

        // 257 words back-to-back
        do_reset();
        n = 0;
        k = 0;
        data0 = 8'h05; load0 = 1'b1;
        while (n < 257 && k < 5000) begin
            if (ready0) begin
                push0(data0);
                n++;
            end
            tick();
            k++;
            if (n == 257) load0 = 1'b0;
            else          data0 = 8'((n * 37) + 5);
        end
        while (busy0 && k < 5000) begin
            tick();
            k++;
        end
        check("t5_timeout",    busy0, 0);
        check("t5_stream_len", k, 2057);
        check("t5_words",      ws0, 1);
        check("t5_drain",      q0.size(), 0);

        // LSB first, load while full is dropped
        do_reset();
        data1 = 8'h01; load1 = 1'b1; push1(8'h01);
        tick();
        check("t6_ready_hold", ready1, 1);
        data1 = 8'h80; push1(8'h80);
        tick();
        check("t6_ready_drop", ready1, 0);
        data1 = 8'hFF;
        tick();
        load1 = 1'b0;
        repeat (14) tick();
        check("t6_idle",  busy1, 0);
        check("t6_words", ws1, 2);
        check("t6_drain", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
